// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential shift-and-add multiplier.
//   state_t     - controller state encoding (IDLE / RUN / DONE)
//   MIN_WIDTH   - smallest legal operand width
//   MAX_WIDTH   - largest legal operand width
//   cnt_width() - iteration counter width for a given operand width
package seq_mult_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH-1 (the last iteration index).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: WIDTH-bit ripple-carry adder built from full-adder stages.
//   x, y  - addends (WIDTH bits, unsigned)
//   sum   - low WIDTH bits of x + y
//   cout  - carry out of the top stage
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_nxn.sv
// seq_mult_nxn: unsigned WIDTH x WIDTH radix-2 shift-and-add multiplier.
// One iteration per clock using a single shared adder_nbit; WIDTH cycles of
// busy, then a one-cycle done pulse with the 2*WIDTH-bit product on result.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous, active-high reset (highest priority)
//   start       - operation request, accepted in IDLE or DONE
//   a, b        - multiplicand / multiplier, captured on an accepted start
//   signed_mode - (SEQ_MULT_SIGNED_EN only) treat a, b as two's complement
//   busy        - high while iterating
//   done        - one-cycle completion pulse
//   result      - product, held until the next completion or reset
//
// Build option: define SEQ_MULT_SIGNED_EN to add the signed_mode port.
module seq_mult_nxn
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("seq_mult_nxn: WIDTH must lie in [MIN_WIDTH, MAX_WIDTH]");
    end

    state_t             state, state_next;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   shift_lo;
    logic [CNT_W-1:0]   count;
    logic               neg_r;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_in;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] product;

    // Operand conditioning: in signed mode iterate on magnitudes and fix the
    // sign at completion. The magnitude of -2^(WIDTH-1) still fits unsigned.
`ifdef SEQ_MULT_SIGNED_EN
    assign neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;
`else
    assign neg_in = 1'b0;
    assign a_mag  = a;
    assign b_mag  = b;
`endif

    assign addend = shift_lo[0] ? mcand : '0;

    adder_nbit #(.WIDTH(WIDTH)) u_add (
        .x    (acc_hi),
        .y    (addend),
        .sum  (sum),
        .cout (cout)
    );

    // {cout, sum, shift_lo} shifted right by one: the full product once the
    // last iteration has been folded in.
    assign product   = {cout, sum, shift_lo[WIDTH-1:1]};
    assign last_iter = (state == RUN) && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            acc_hi   <= '0;
            shift_lo <= '0;
            count    <= '0;
            neg_r    <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            mcand    <= a_mag;
            shift_lo <= b_mag;
            acc_hi   <= '0;
            count    <= '0;
            neg_r    <= neg_in;
        end else if (state == RUN) begin
            acc_hi   <= {cout, sum[WIDTH-1:1]};
            shift_lo <= {sum[0], shift_lo[WIDTH-1:1]};
            count    <= count + CNT_W'(1);
            if (last_iter) begin
                result <= neg_r ? -product : product;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_nxn.sv
module tb_seq_mult_nxn;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
`ifdef SEQ_MULT_SIGNED_EN
    logic        signed_mode;
`endif
    logic        busy;
    logic        done;
    logic [15:0] result;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [15:0] sb_q[$];

    seq_mult_nxn #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        int pa;
        int pb;
        int p;
        if (sm) begin
            pa = int'($signed(av));
            pb = int'($signed(bv));
        end else begin
            pa = int'(av);
            pb = int'(bv);
        end
        p = pa * pb;
        return p[15:0];
    endfunction

    // Called at a falling edge; returns one falling edge after the accept edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sm, input bit expect_it);
        a = av;
        b = bv;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = sm;
`endif
        start = 1'b1;
        if (expect_it) sb_q.push_back(model(av, bv, sm));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    // Scoreboard: every done pulse must match the oldest expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check("sb_has_entry_at_done", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("result_at_done", 32'(result), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 13 x 11: eight busy cycles, one done cycle, result held afterwards
        start_op(8'd13, 8'd11, 1'b0, 1'b1);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done("latency_13x11", 8);
        @(negedge clk);
        check("done_one_cycle",   32'(done),   32'd0);
        check("busy_after_done",  32'(busy),   32'd0);
        check("result_held",      32'(result), 32'h008F);
        repeat (3) @(negedge clk);
        check("result_held_idle", 32'(result), 32'h008F);

        // Extremes: 255 x 255 and a zero operand
        start_op(8'd255, 8'd255, 1'b0, 1'b1);
        check("result_unchanged_in_run", 32'(result), 32'h008F);
        wait_done("latency_255x255", 8);
        @(negedge clk);
        start_op(8'd0, 8'd200, 1'b0, 1'b1);
        wait_done("latency_0x200", 8);
        @(negedge clk);

        // Back-to-back with start held high; operand changes during RUN ignored
        d0 = done_cnt;
        a = 8'd3; b = 8'd5; start = 1'b1;
        sb_q.push_back(model(8'd3, 8'd5, 1'b0));
        sb_q.push_back(model(8'd7, 8'd9, 1'b0));
        @(negedge clk);
        a = 8'd7; b = 8'd9;
        wait_done("latency_b2b_first", 8);
        @(negedge clk);
        check("busy_done_to_run", 32'(busy), 32'd1);
        check("done_drops_on_restart", 32'(done), 32'd0);
        wait_done("latency_b2b_second", 8);
        start = 1'b0;
        @(negedge clk);
        check("idle_after_b2b_busy", 32'(busy), 32'd0);
        check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

        // start while busy: in-flight 13 x 11 unaffected, no extra done
        d0 = done_cnt;
        start_op(8'd13, 8'd11, 1'b0, 1'b1);
        start_op(8'd100, 8'd100, 1'b0, 1'b0);
        wait_done("latency_midrun_start", 7);
        repeat (12) @(negedge clk);
        check("midrun_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("midrun_result", 32'(result), 32'h008F);

        // Reset during the fourth RUN cycle aborts with no done
        start_op(8'd255, 8'd255, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        start_op(8'd13, 8'd11, 1'b0, 1'b1);
        wait_done("latency_after_abort", 8);
        @(negedge clk);

        // 0xFD x 5 unsigned
        start_op(8'hFD, 8'd5, 1'b0, 1'b1);
        wait_done("latency_fd_x5", 8);
        @(negedge clk);
        check("unsigned_fd_x5", 32'(result), 32'h04F1);

`ifdef SEQ_MULT_SIGNED_EN
        start_op(8'hFD, 8'd5, 1'b1, 1'b1);
        wait_done("latency_signed_m3x5", 8);
        @(negedge clk);
        check("signed_m3x5", 32'(result), 32'hFFF1);
        start_op(8'h80, 8'h80, 1'b1, 1'b1);
        wait_done("latency_signed_min", 8);
        @(negedge clk);
        check("signed_min_x_min", 32'(result), 32'h4000);
        start_op(8'd7, 8'hF7, 1'b1, 1'b1);
        wait_done("latency_signed_7xm9", 8);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
